// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Upstream control stage for alu_datapath. Takes one operand-pair command at a
// time on a valid/ready interface and serialises it into the datapath load
// protocol: store_a, store_b, then a single-cycle start. It then waits for
// alu_done, captures result/overflow and presents them on a valid/ready
// response interface. At most one command is in flight.
//
// Parameters:
//   DATA_WIDTH      operand/result width, matches the datapath
//   TIMEOUT_CYCLES  WAIT-cycle limit before an error response (>= 1); only
//                   used when ALU_SEQ_TIMEOUT_EN is defined
//
// Build option:
//   ALU_SEQ_TIMEOUT_EN  when defined, a WAIT that sees no alu_done for
//                       TIMEOUT_CYCLES cycles ends in an error response.
//                       When undefined, resp_error is always 0 and WAIT
//                       lasts until alu_done.
//
// Ports:
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_opcode, cmd_a, cmd_b    00 ADD, 01 SUB, 10 PAR, 11 COMP; operands
//   alu_data, opcode_value      operand bus and opcode to the datapath
//   store_a, store_b, start     datapath load strobes and start pulse
//   alu_done, result, overflow  datapath completion and outputs
//   resp_valid/resp_ready       response handshake
//   resp_result, resp_overflow  captured result; overflow masked for PAR/COMP
//   resp_error                  timeout flag
//
// All outputs are registered.

module alu_op_sequencer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  // Command interface
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  // Datapath interface
  output logic [DATA_WIDTH-1:0] alu_data,
  output logic [1:0]            opcode_value,
  output logic                  store_a,
  output logic                  store_b,
  output logic                  start,
  input  logic                  alu_done,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  overflow,
  // Response interface
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  resp_overflow,
  output logic                  resp_error
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StStart,
    StWait,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Registered command fields. Operand A needs no separate holding register:
  // it is only ever driven during LOAD_A, so it goes straight into alu_data_q
  // on the accept edge.
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] b_q;

  // Output registers and their next-state values
  logic                  cmd_ready_q, cmd_ready_d;
  logic [DATA_WIDTH-1:0] alu_data_q, alu_data_d;
  logic [1:0]            opcode_q, opcode_d;
  logic                  store_a_q, store_a_d;
  logic                  store_b_q, store_b_d;
  logic                  start_q, start_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
  logic                  resp_overflow_q, resp_overflow_d;
  logic                  resp_error_q, resp_error_d;

  logic accept;
  logic done_hit;
  logic timeout_hit;

  // cmd_ready_q is only ever high in IDLE, so this is the full handshake.
  assign accept   = (state_q == StIdle) && cmd_valid && cmd_ready_q;
  assign done_hit = (state_q == StWait) && alu_done;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  // Counts WAIT cycles without alu_done. Held at zero outside WAIT so it is
  // clear on every WAIT entry.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q != StWait) begin
      wait_cnt_d = '0;
    end else if (!alu_done) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // The count reaches TIMEOUT_CYCLES on this edge; alu_done in the same
  // cycle takes priority and gives a normal response.
  assign timeout_hit = (state_q == StWait) && !alu_done &&
                       (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = (TIMEOUT_CYCLES == 0);
  assign timeout_hit           = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoadA;
        end
      end
      StLoadA: state_d = StLoadB;
      StLoadB: state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        if (done_hit || timeout_hit) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath-side outputs, decoded from the state being entered so that they
  // line up with the state once registered.
  always_comb begin
    cmd_ready_d  = (state_d == StIdle);
    store_a_d    = (state_d == StLoadA);
    store_b_d    = (state_d == StLoadB);
    start_d      = (state_d == StStart);
    resp_valid_d = (state_d == StResp);
    alu_data_d   = '0;
    opcode_d     = 2'b00;
    unique case (state_d)
      StLoadA: begin
        // Only reachable from IDLE on accept, so the command bus is current.
        alu_data_d = cmd_a;
        opcode_d   = cmd_opcode;
      end
      StLoadB, StStart: begin
        alu_data_d = b_q;
        opcode_d   = op_q;
      end
      StWait: begin
        opcode_d = op_q;
      end
      default: begin
      end
    endcase
  end

  // Response capture: held stable through RESP, cleared after the handshake.
  always_comb begin
    resp_result_d   = resp_result_q;
    resp_overflow_d = resp_overflow_q;
    resp_error_d    = resp_error_q;
    if (done_hit) begin
      resp_result_d   = result;
      // Overflow is meaningful only for ADD/SUB (opcode MSB clear).
      resp_overflow_d = overflow & ~op_q[1];
      resp_error_d    = 1'b0;
    end else if (timeout_hit) begin
      resp_result_d   = '0;
      resp_overflow_d = 1'b0;
      resp_error_d    = 1'b1;
    end else if ((state_q == StResp) && resp_ready) begin
      resp_result_d   = '0;
      resp_overflow_d = 1'b0;
      resp_error_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      op_q            <= 2'b00;
      b_q             <= '0;
      cmd_ready_q     <= 1'b0;
      alu_data_q      <= '0;
      opcode_q        <= 2'b00;
      store_a_q       <= 1'b0;
      store_b_q       <= 1'b0;
      start_q         <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_result_q   <= '0;
      resp_overflow_q <= 1'b0;
      resp_error_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      if (accept) begin
        op_q <= cmd_opcode;
        b_q  <= cmd_b;
      end
      cmd_ready_q     <= cmd_ready_d;
      alu_data_q      <= alu_data_d;
      opcode_q        <= opcode_d;
      store_a_q       <= store_a_d;
      store_b_q       <= store_b_d;
      start_q         <= start_d;
      resp_valid_q    <= resp_valid_d;
      resp_result_q   <= resp_result_d;
      resp_overflow_q <= resp_overflow_d;
      resp_error_q    <= resp_error_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign alu_data      = alu_data_q;
  assign opcode_value  = opcode_q;
  assign store_a       = store_a_q;
  assign store_b       = store_b_q;
  assign start         = start_q;
  assign resp_valid    = resp_valid_q;
  assign resp_result   = resp_result_q;
  assign resp_overflow = resp_overflow_q;
  assign resp_error    = resp_error_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream control stage for `alu_datapath`. Accepts one operand-pair command at a time on a valid/ready interface and serialises it into the datapath's load protocol: `store_a`, then `store_b`, then a one-cycle `start`. It then waits for `alu_done`, captures `result`/`overflow` and returns them on a valid/ready response interface. It is the only driver of the datapath's `alu_data`, `opcode_value`, `store_a`, `store_b` and `start` inputs.

## Interface
Parameters:
- `DATA_WIDTH`, default 8, operand/result width; matches the datapath.
- `TIMEOUT_CYCLES`, default 16, maximum WAIT cycles before an error response. Used only with `ALU_SEQ_TIMEOUT_EN`; legal range ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_opcode`  in  2  00 ADD, 01 SUB, 10 PAR, 11 COMP.
- `cmd_a`  in  DATA_WIDTH  operand A.
- `cmd_b`  in  DATA_WIDTH  operand B.
- `alu_data`  out  DATA_WIDTH  operand bus to the datapath.
- `opcode_value`  out  2  opcode to the datapath.
- `store_a`  out  1  load-A strobe.
- `store_b`  out  1  load-B strobe.
- `start`  out  1  one-cycle start pulse.
- `alu_done`  in  1  datapath completion.
- `result`  in  DATA_WIDTH  datapath result.
- `overflow`  in  1  datapath overflow/borrow.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_result`  out  DATA_WIDTH  captured result.
- `resp_overflow`  out  1  captured overflow; forced 0 for PAR and COMP.
- `resp_error`  out  1  timeout flag.

## Operation
- FSM states: IDLE → LOAD_A → LOAD_B → START → WAIT → RESP → IDLE.
- **IDLE**
  - `cmd_ready`=1; all strobes 0.
  - On `cmd_valid && cmd_ready`, register opcode, A and B, then go to LOAD_A.
- **LOAD_A:** `store_a`=1, `alu_data`=A.
- **LOAD_B:** `store_b`=1, `alu_data`=B.
- **START:** `start`=1 for exactly one cycle; `alu_data` holds B.
- `opcode_value` holds the registered opcode from LOAD_A through WAIT, and is 0 in IDLE and RESP.
- **WAIT**
  - All strobes 0.
  - When `alu_done`=1, capture `result` into `resp_result`.
  - Capture `overflow` into `resp_overflow` only when the opcode is ADD or SUB; otherwise capture 0.
  - Go to RESP.
  - `alu_done` is ignored in every state other than WAIT.
- **RESP**
  - `resp_valid`=1; response outputs are held stable until `resp_valid && resp_ready`, then go to IDLE.
  - `cmd_ready`=0 in every state except IDLE, so there is at most one command in flight.
- **Reset:** from any state, including mid-operation, the FSM returns to IDLE.
  - All outputs go to 0, except `cmd_ready`, which is 1 in the first cycle after reset deasserts.
  - Any in-flight command and any pending response are discarded.

## Timing
- Command accepted at edge E0.
- LOAD_A occupies the cycle after E0, LOAD_B the next cycle, START the one after that. WAIT is entered on the following edge.
- If `alu_done` is high in WAIT cycle k, `resp_valid` rises at the next edge.
- Minimum command-to-response latency is 5 cycles (`alu_done` in the first WAIT cycle).
- `resp_valid` may be asserted before `resp_ready`; zero-cycle handoff is allowed. A new command can be accepted the cycle after the response handshake.
- Strobes are registered outputs; at most one of `store_a`/`store_b`/`start` is high in any cycle.

## Configuration
- Macro: `ALU_SEQ_TIMEOUT_EN`.
- **Defined:**
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on WAIT entry and increments each WAIT cycle without `alu_done`.
  - When it reaches `TIMEOUT_CYCLES`, go to RESP with `resp_error`=1, `resp_result`=0, `resp_overflow`=0.
  - If `alu_done` and the terminal count coincide, `alu_done` wins (normal response, `resp_error`=0).
- **Undefined:** no counter; `resp_error` is tied to 0; WAIT lasts indefinitely until `alu_done`.

## Test plan
- **Reset:** assert `reset` in the middle of WAIT → the next cycle has all outputs 0; after release, `cmd_ready`=1 and `resp_valid`=0; a late `alu_done` is ignored.
- **ADD with overflow** (DATA_WIDTH=8): A=8'h7F, B=8'h01; model asserts `alu_done` in the 2nd WAIT cycle with `result`=8'h80, `overflow`=1 → check strobe order A/B/start on three consecutive cycles with `alu_data` 7F then 01; response 8'h80, overflow 1, `resp_valid` 6 cycles after accept.
- **PAR with overflow masking:** opcode 10, model drives `overflow`=1 with `result`=8'h3C → `resp_overflow`=0, `resp_result`=8'h3C.
- **Response backpressure:** hold `resp_ready`=0 for 4 cycles → response stays stable, `cmd_ready` stays 0 while `cmd_valid`=1; the command is accepted the cycle after the handshake.
- **Timeout** (`ALU_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES=16): no `alu_done` → `resp_error`=1 and `resp_result`=0 after 16 WAIT cycles. Repeat with `alu_done` on the 16th WAIT cycle → `resp_error`=0.
- **Back-to-back:** SUB 8'h00−8'h01 then COMP with `resp_ready` tied 1 → the first response has `resp_result`=8'hFF and `resp_overflow`=1; the second command's LOAD_A follows with a one-cycle IDLE gap.
